// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and default constants for the UART receive path.
//                rx_state_e   - receiver FSM state encoding
//                UART_*       - default baud-generator settings
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_CLK_DIV    = 27;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous FIFO, WIDTH x DEPTH (DEPTH power of 2, >= 2).
//                A push while full is accepted only if a pop happens in the
//                same cycle; a pop while empty is ignored.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                push_i/data_i - write request and data
//                pop_i         - read request (advances head)
//                data_o        - head entry
//                full_o/empty_o- occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W:0]  wr_ptr_q;
    logic [ADDR_W:0]  rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Oversampling baud generator with
//                mid-bit sampling, configurable data/parity/stop format,
//                per-character frame/parity flags and a receive FIFO with a
//                valid/ready output handshake.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                rx_i           - serial line (idle high, asynchronous)
//                rx_data_o      - head character
//                rx_valid_o     - FIFO non-empty
//                rx_ready_i     - consumer accepts head character
//                frame_err_o    - head character had a low stop bit
//                parity_err_o   - head character failed parity
//                overrun_o      - pulse: completed character dropped (full)
//                busy_o         - receiver not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = UART_CLK_DIV,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W   = $clog2(DATA_BITS);
    localparam int unsigned ENTRY_W = DATA_BITS + 2;

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    rx_state_e            state_q,    state_d;
    logic [DIV_W-1:0]     div_cnt_q,  div_cnt_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q;

    logic      w_tick;
    logic      w_bit_end;
    logic      w_last_stop;
    logic      w_push;
    rx_entry_t w_push_entry;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic [ENTRY_W-1:0] w_fifo_rdata;
    rx_entry_t w_head;

    assign w_tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign w_bit_end   = w_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = w_tick ? '0 : div_cnt_q + DIV_W'(1);
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        // Within a bit, count ticks; the bit-end tick wraps to 0.
        if (w_tick && state_q != RX_IDLE && state_q != RX_BREAK) begin
            tick_cnt_d = w_bit_end ? '0 : tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    // Re-phase the divider to the start edge so that the
                    // half-bit count lands on the centre of the start bit.
                    state_d    = RX_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (w_tick && tick_cnt_q == TICK_W'(OVERSAMPLE/2 - 1)) begin
                    tick_cnt_d = '0;
                    if (!rxs_q) begin
                        state_d      = RX_DATA;
                        bit_idx_d    = '0;
                        frame_err_d  = 1'b0;
                        parity_err_d = 1'b0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (w_bit_end) begin
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (w_bit_end) begin
                    parity_err_d = ((^shift_q) ^ rxs_q) != 1'(PARITY_ODD);
                    state_d      = RX_STOP;
                    stop_idx_d   = 1'b0;
                end
            end
            RX_STOP: begin
                if (w_bit_end) begin
                    if (!rxs_q) frame_err_d = 1'b1;
                    if (w_last_stop) state_d = rxs_q ? RX_IDLE : RX_BREAK;
                    else             stop_idx_d = 1'b1;
                end
            end
            RX_BREAK: begin
                if (rxs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Output logic: the push carries the final stop sample directly so the
    // character enters the FIFO on the same edge that samples it.
    always_comb begin
        busy_o                  = (state_q != RX_IDLE);
        w_push                  = (state_q == RX_STOP) && w_bit_end && w_last_stop;
        w_push_entry.frame_err  = frame_err_q | ~rxs_q;
        w_push_entry.parity_err = parity_err_q;
        w_push_entry.data       = shift_q;
    end

    // ------------------------------------------------------------------
    // Receive FIFO and handshake
    // ------------------------------------------------------------------
    assign w_pop = ~w_empty & rx_ready_i;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= w_push & w_full & ~w_pop;
    end

    assign w_head       = w_fifo_rdata;
    assign rx_valid_o   = ~w_empty;
    // Outputs read as zero while the FIFO holds nothing.
    assign rx_data_o    = w_empty ? '0   : w_head.data;
    assign frame_err_o  = w_empty ? 1'b0 : w_head.frame_err;
    assign parity_err_o = w_empty ? 1'b0 : w_head.parity_err;
    assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Scoreboard bench for uart_rx_param. dut_a is 8N1 with a
//                4-entry FIFO, dut_p is 8E1. Expected characters are queued
//                as {frame_err, parity_err, data} when a frame is sent;
//                monitors pop on every valid&ready cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int BIT = 64;   // CLK_DIV 4 x OVERSAMPLE 16

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, ready_a = 1'b1;
    logic rx_p = 1'b1, ready_p = 1'b1;

    logic [7:0] data_a, data_p;
    logic valid_a, fe_a, pe_a, ovr_a, busy_a;
    logic valid_p, fe_p, pe_p, ovr_p, busy_p;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .rx_data_o(data_a),
        .rx_valid_o(valid_a), .rx_ready_i(ready_a), .frame_err_o(fe_a),
        .parity_err_o(pe_a), .overrun_o(ovr_a), .busy_o(busy_a)
    );

    uart_rx_param #(
        .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .rst(rst), .rx_i(rx_p), .rx_data_o(data_p),
        .rx_valid_o(valid_p), .rx_ready_i(ready_p), .frame_err_o(fe_p),
        .parity_err_o(pe_p), .overrun_o(ovr_p), .busy_o(busy_p)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_p = 0;
    int busy_cnt_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_p[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (ovr_a)  ovr_cnt_a++;
        if (ovr_p)  ovr_cnt_p++;
        if (busy_a) busy_cnt_a++;
        if (valid_a && ready_a) begin
            if (q_a.size() == 0) chk("a_unexpected_char", {fe_a, pe_a, data_a}, 32'h3ff);
            else                 chk("a_char", {fe_a, pe_a, data_a}, q_a.pop_front());
        end
        if (valid_p && ready_p) begin
            if (q_p.size() == 0) chk("p_unexpected_char", {fe_p, pe_p, data_p}, 32'h3ff);
            else                 chk("p_char", {fe_p, pe_p, data_p}, q_p.pop_front());
        end
    end

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx_a = v;
    endtask

    // One frame: start, 8 data LSB first, optional parity, one stop bit.
    // A low stop level is left on the line for the caller to continue.
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                        input logic par, input logic stop);
        @(negedge clk);
        drive(sel, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            repeat (BIT) @(negedge clk);
        end
        if (has_par) begin
            drive(sel, par);
            repeat (BIT) @(negedge clk);
        end
        drive(sel, stop);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic set_ready_a(input logic v);
        @(posedge clk);
        #1 ready_a = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},   valid_a, 0);
        chk({tag, "_data"},    data_a,  0);
        chk({tag, "_ferr"},    fe_a,    0);
        chk({tag, "_perr"},    pe_a,    0);
        chk({tag, "_overrun"}, ovr_a,   0);
        chk({tag, "_busy"},    busy_a,  0);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int b0, o0, d;
        bit drained;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_valid_p", valid_p, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Basic 8N1 frame
        b0 = busy_cnt_a;
        q_a.push_back({2'b00, 8'hA5});
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        repeat (BIT) @(negedge clk);
        d = busy_cnt_a - b0;
        chk("basic_busy_len_600_616", (d >= 600 && d <= 616), 1);
        chk("basic_idle_after", busy_a, 0);

        // False start
        @(negedge clk);
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("false_start_busy_seen", busy_a, 1);
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        repeat (2*BIT) @(negedge clk);
        chk("false_start_idle", busy_a, 0);
        chk("false_start_no_valid", valid_a, 0);

        // Parity (even): 0x03 has even ones, so parity bit 1 is wrong
        q_p.push_back({2'b01, 8'h03});
        send(1, 8'h03, 1, 1'b1, 1'b1);
        q_p.push_back({2'b00, 8'h03});
        send(1, 8'h03, 1, 1'b0, 1'b1);
        q_p.push_back({2'b00, 8'h07});
        send(1, 8'h07, 1, 1'b1, 1'b1);
        repeat (BIT) @(negedge clk);

        // Framing error then break
        q_a.push_back({2'b10, 8'h55});
        send(0, 8'h55, 0, 1'b0, 1'b0);
        repeat (3*BIT) @(negedge clk);
        chk("break_busy", busy_a, 1);
        chk("break_delivered_count", q_a.size(), 0);
        rx_a = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("break_exit_idle", busy_a, 0);
        q_a.push_back({2'b00, 8'h12});
        send(0, 8'h12, 0, 1'b0, 1'b1);
        repeat (BIT) @(negedge clk);

        // Overrun: five frames into a 4-deep FIFO with no consumer
        set_ready_a(1'b0);
        o0 = ovr_cnt_a;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q_a.push_back({2'b00, 8'(k)});
            send(0, 8'(k), 0, 1'b0, 1'b1);
            if (k == 4) chk("overrun_none_at_4", ovr_cnt_a - o0, 0);
        end
        chk("overrun_once_at_5", ovr_cnt_a - o0, 1);
        chk("overrun_head_valid", valid_a, 1);
        chk("overrun_head_stable", data_a, 8'h01);
        set_ready_a(1'b1);
        drained = 0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(negedge clk);
            drained = (q_a.size() == 0);
        end
        chk("overrun_drained", drained, 1);
        repeat (2) @(negedge clk);
        chk("overrun_empty_after", valid_a, 0);

        // Reset mid-frame with a character waiting in the FIFO
        set_ready_a(1'b0);
        send(0, 8'h77, 0, 1'b0, 1'b1);
        @(negedge clk);
        rx_a = 1'b0;
        repeat (BIT) @(negedge clk);
        rx_a = 1'b1;
        repeat (4*BIT + BIT/2) @(negedge clk);
        chk("midframe_busy", busy_a, 1);
        chk("midframe_fifo_holds", {valid_a, data_a}, {1'b1, 8'h77});
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        set_ready_a(1'b1);
        repeat (2*BIT) @(negedge clk);
        chk("post_reset_no_valid", valid_a, 0);
        q_a.push_back({2'b00, 8'h3C});
        send(0, 8'h3C, 0, 1'b0, 1'b1);

        // Everything expected must have been delivered
        drained = 0;
        for (int c = 0; c < 4*BIT && !drained; c++) begin
            @(negedge clk);
            drained = (q_a.size() == 0) && (q_p.size() == 0);
        end
        chk("final_all_delivered", drained, 1);
        chk("final_overrun_total_a", ovr_cnt_a, 1);
        chk("final_overrun_total_p", ovr_cnt_p, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
